// File: rtl/xcache_axi4_mem_slave_if.sv
// xcache_axi4_mem_slave_if: AXI4 bus between the bank arbiter (master) and the memory responder (slave)
interface xcache_axi4_mem_slave_if #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 256,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ID_WIDTH   = 8
);
   logic                        axi_awvalid;
   logic                        axi_awready;
   logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
   logic [AXI_LEN_WIDTH-1:0]    axi_awlen;
   logic [AXI_ID_WIDTH-1:0]     axi_awid;
   logic                        axi_wvalid;
   logic                        axi_wready;
   logic [AXI_DATA_WIDTH-1:0]   axi_wdata;
   logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb;
   logic                        axi_wlast;
   logic                        axi_bvalid;
   logic                        axi_bready;
   logic [1:0]                  axi_bresp;
   logic [AXI_ID_WIDTH-1:0]     axi_bid;
   logic                        axi_arvalid;
   logic                        axi_arready;
   logic [AXI_ADDR_WIDTH-1:0]   axi_araddr;
   logic [AXI_LEN_WIDTH-1:0]    axi_arlen;
   logic [AXI_ID_WIDTH-1:0]     axi_arid;
   logic                        axi_rvalid;
   logic                        axi_rready;
   logic [AXI_DATA_WIDTH-1:0]   axi_rdata;
   logic                        axi_rlast;
   logic [1:0]                  axi_rresp;
   logic [AXI_ID_WIDTH-1:0]     axi_rid;

   modport slave (
      input  axi_awvalid, axi_awaddr, axi_awlen, axi_awid,
      output axi_awready,
      input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
      output axi_wready,
      output axi_bvalid, axi_bresp, axi_bid,
      input  axi_bready,
      input  axi_arvalid, axi_araddr, axi_arlen, axi_arid,
      output axi_arready,
      output axi_rvalid, axi_rdata, axi_rlast, axi_rresp, axi_rid,
      input  axi_rready
   );

   modport master (
      output axi_awvalid, axi_awaddr, axi_awlen, axi_awid,
      input  axi_awready,
      output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
      input  axi_wready,
      input  axi_bvalid, axi_bresp, axi_bid,
      output axi_bready,
      output axi_arvalid, axi_araddr, axi_arlen, axi_arid,
      input  axi_arready,
      input  axi_rvalid, axi_rdata, axi_rlast, axi_rresp, axi_rid,
      output axi_rready
   );
endinterface

// File: rtl/xcache_axi4_mem_slave.sv
// xcache_axi4_mem_slave: single-port RAM behind an AXI4 slave serving one INCR burst at a time
module xcache_axi4_mem_slave #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 256,
   parameter int AXI_LEN_WIDTH  = 8,
   parameter int AXI_ID_WIDTH   = 8,
   parameter int MEM_BYTE       = 65536
) (
   input  logic                   clk,
   input  logic                   rstn,
   xcache_axi4_mem_slave_if.slave axi,
   output logic                   proto_err
);
   localparam int NB    = AXI_DATA_WIDTH / 8;
   localparam int WORDS = MEM_BYTE / NB;
   localparam int OB    = $clog2(NB);
   localparam int IW    = $clog2(WORDS);
   localparam logic [IW-1:0]            IDX_ONE = 1;
   localparam logic [AXI_LEN_WIDTH-1:0] CNT_ONE = 1;

   typedef enum logic [2:0] {IDLE, WDATA, WRESP, RFETCH, RDATA} state_t;

   state_t                    state, state_d;
   logic                      last_wr;
   logic [IW-1:0]             idx;
   logic [AXI_LEN_WIDTH-1:0]  cnt;
   logic [AXI_ID_WIDTH-1:0]   id;
   logic [AXI_DATA_WIDTH-1:0] mem [WORDS];
   logic [AXI_DATA_WIDTH-1:0] rdata;
   logic                      aw_go, ar_go, w_beat, r_beat, done, re;
   logic                      unused_addr;

   assign unused_addr = ^{axi.axi_awaddr, axi.axi_araddr};
   assign done  = cnt == '0;
   // round robin: the channel not served last wins a tie
   assign aw_go = rstn && state == IDLE && axi.axi_awvalid && (!axi.axi_arvalid || !last_wr);
   assign ar_go = rstn && state == IDLE && axi.axi_arvalid && !aw_go;
   assign axi.axi_awready = aw_go;
   assign axi.axi_arready = ar_go;
   assign axi.axi_wready  = rstn && state == WDATA;
   assign axi.axi_bvalid  = rstn && state == WRESP;
   assign axi.axi_rvalid  = rstn && state == RDATA;
   assign axi.axi_bresp   = 2'b00;
   assign axi.axi_rresp   = 2'b00;
   assign axi.axi_bid     = id;
   assign axi.axi_rid     = id;
   assign axi.axi_rdata   = rdata;
   assign axi.axi_rlast   = axi.axi_rvalid && done;
   assign w_beat = axi.axi_wready && axi.axi_wvalid;
   assign r_beat = axi.axi_rvalid && axi.axi_rready;
   // prefetch the next word on each accepted beat so rvalid never drops mid-burst
   assign re = state == RFETCH || (r_beat && !done);

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = aw_go ? WDATA : ar_go ? RFETCH : IDLE;
         WDATA:   state_d = (w_beat && done) ? WRESP : WDATA;
         WRESP:   state_d = axi.axi_bready ? IDLE : WRESP;
         RFETCH:  state_d = RDATA;
         RDATA:   state_d = (r_beat && done) ? IDLE : RDATA;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else state <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         last_wr   <= 1'b0;
         idx       <= '0;
         cnt       <= '0;
         id        <= '0;
         proto_err <= 1'b0;
         rdata     <= '0;
      end else begin
         if (aw_go) begin
            idx <= axi.axi_awaddr[OB +: IW];
            cnt <= axi.axi_awlen;
            id  <= axi.axi_awid;
         end
         if (ar_go) begin
            idx <= axi.axi_araddr[OB +: IW];
            cnt <= axi.axi_arlen;
            id  <= axi.axi_arid;
         end
         if (w_beat || (r_beat && !done)) begin
            idx <= idx + IDX_ONE;
            cnt <= cnt - CNT_ONE;
         end
         if (w_beat && axi.axi_wlast != done) proto_err <= 1'b1;
         if (state == WRESP && axi.axi_bready) last_wr <= 1'b1;
         if (r_beat && done) last_wr <= 1'b0;
         if (re) rdata <= mem[state == RFETCH ? idx : idx + IDX_ONE];
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat)
         for (int b = 0; b < NB; b++)
            if (axi.axi_wstrb[b]) mem[idx][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
   end
endmodule

// File: doc/xcache_axi4_mem_slave.md
# xcache_axi4_mem_slave

AXI4 slave memory responder that terminates the main-memory AXI4 port driven by the xcache bank AXI4 arbiter. It serves INCR read and write bursts from an on-chip single-port RAM of `MEM_BYTE` bytes. It is the simulation/FPGA backing store behind cyclic and MRU cache banks. It handles one transaction at a time, with round-robin arbitration between the read and write address channels.

## Interface
- `AXI_ADDR_WIDTH`, 32, AXI address width (byte address)
- `AXI_DATA_WIDTH`, 256, AXI data width; one RAM word per beat
- `AXI_LEN_WIDTH`, 8, burst length field width (beats = len+1)
- `AXI_ID_WIDTH`, 8, transaction ID width
- `MEM_BYTE`, 65536, RAM size in bytes; power of two, multiple of `AXI_DATA_WIDTH/8`
- `clk` in 1: single clock, rising edge
- `rstn` in 1: reset, synchronous, active-low
- `axi_awvalid` in 1, `axi_awready` out 1, `axi_awaddr` in AXI_ADDR_WIDTH, `axi_awlen` in AXI_LEN_WIDTH, `axi_awid` in AXI_ID_WIDTH: write address channel
- `axi_wvalid` in 1, `axi_wready` out 1, `axi_wdata` in AXI_DATA_WIDTH, `axi_wstrb` in AXI_DATA_WIDTH/8, `axi_wlast` in 1: write data channel
- `axi_bvalid` out 1, `axi_bready` in 1, `axi_bresp` out 2, `axi_bid` out AXI_ID_WIDTH: write response channel
- `axi_arvalid` in 1, `axi_arready` out 1, `axi_araddr` in AXI_ADDR_WIDTH, `axi_arlen` in AXI_LEN_WIDTH, `axi_arid` in AXI_ID_WIDTH: read address channel
- `axi_rvalid` out 1, `axi_rready` in 1, `axi_rdata` out AXI_DATA_WIDTH, `axi_rlast` out 1, `axi_rresp` out 2, `axi_rid` out AXI_ID_WIDTH: read data channel
- `proto_err` out 1: sticky flag; `axi_wlast` disagreed with the beat count

## Operation
- Size, burst, lock, cache, prot, qos, and region fields are not ports. Full-width INCR is implied.
- Word index = `(addr / (AXI_DATA_WIDTH/8)) mod (MEM_BYTE/(AXI_DATA_WIDTH/8))`. Low byte-offset bits are ignored. Index increments per beat and wraps to 0 at the top of the RAM.
- FSM states: IDLE, WDATA, WRESP, RFETCH, RDATA.
- **IDLE:**
  - Only awvalid set: awready=1.
  - Only arvalid set: arready=1.
  - Both set: grant the channel not granted last (`last_wr` flag; reset value 0, so write wins first).
  - Exactly one ready is asserted, combinationally from valid, state and `last_wr`.
  - On handshake, capture addr, len and id; load beat counter = len.
  - AW handshake goes to WDATA. AR handshake goes to RFETCH.
- **WDATA:**
  - wready=1.
  - Each wvalid beat writes RAM bytes where wstrb=1 at the current index. Index increments and counter decrements.
  - Beat with counter==0 goes to WRESP.
  - Mismatch sets proto_err: wlast=1 with counter≠0, or wlast=0 with counter==0. The burst still runs exactly len+1 beats.
- **WRESP:**
  - bvalid=1, bresp=0, bid=captured awid.
  - On bready, go to IDLE with last_wr=1.
- **RFETCH:** RAM read at the current index; go to RDATA.
- **RDATA:**
  - rvalid=1, rdata=RAM output register, rid=captured arid, rresp=0, rlast=(counter==0).
  - On an rready beat with counter≠0: issue RAM read at index+1 the same cycle, increment index, decrement counter. New rdata appears next cycle and rvalid stays high.
  - On an rready beat with counter==0: go to IDLE with last_wr=0.
  - With rvalid=1 and rready=0, rdata, rlast and rid hold stable.
- RAM contents are not cleared by reset. Read-after-write returns the written data.

## Timing
- Reset values: all readies, bvalid and rvalid are 0. bid, rid, rdata, bresp, rresp, rlast and proto_err are 0. State=IDLE, last_wr=0.
- Reset asserted mid-burst aborts the transaction. The next cycle is IDLE with no response issued. Partially written beats remain in RAM.
- Read latency: AR handshake at cycle T, RFETCH at T+1, first rvalid at T+2. With rready held high, beat k appears at T+2+k and the last beat at T+2+len. arready returns no earlier than T+3+len.
- Write timing: AW handshake at T, wready at T+1. With wvalid held high, the last beat is at T+1+len and bvalid is at T+2+len.
- No address channel is accepted while a transaction is in flight; throughput is one transaction at a time.
- Simultaneous awvalid/arvalid in IDLE strictly alternates.

## Test plan
- **Reset:** hold rstn=0 for 3 cycles with random inputs. Required: all outputs 0 and no ready asserted during reset.
- **Single write, then read:**
  - Write awaddr=0x40, awlen=0, wstrb=0x0000000F, wdata=0x..DEADBEEF. Required: bvalid with bid=awid and bresp=0.
  - Read araddr=0x40, arlen=0. Required: rdata[31:0]=0xDEADBEEF, other bytes unchanged, rlast=1, rvalid at T+2.
- **Burst with backpressure:** 8-beat write (awlen=7) of incrementing data, then 8-beat read with rready toggled pseudo-randomly. Required: data matches in order, rlast only on beat 7, rdata stable while rready=0.
- **Arbitration:** awvalid and arvalid raised together in the same cycle, repeated 4 times. Required: grant order W,R,W,R.
- **Wrap:** MEM_BYTE=65536, awaddr=0xFFE0, awlen=1. Required: beat 1 lands at word 0; a read of araddr=0x0 returns beat 1.
- **Protocol error and reset mid-burst:**
  - Write with awlen=3 and wlast on beat 1. Required: proto_err=1 (sticky) and 4 beats consumed.
  - A separate read with arlen=7, with rstn pulled low at beat 3. Required: rvalid=0 the next cycle and a new AR is accepted after reset.
